enable_debounce: RTL and testbench

//  Downstream stage of enable_sync. Qualifies the already-synchronised enable level:
//  a level change is accepted only after it has been stable for DEBOUNCE_CYCLES

---
 rtl/enable_debounce_if.sv | 56 +++++
 rtl/enable_debounce.sv | 157 +++++++++++++++
 tb/tb_enable_debounce.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/enable_debounce_if.sv
// Enable-debounce signal bundle: the synchronised enable level going in, and the
// debounced level, edge pulses and busy flag coming out.
// Optional macro ENABLE_GLITCH_CNT_EN adds the glitch_clr / glitch_count pair.
interface enable_debounce_if
`ifdef ENABLE_GLITCH_CNT_EN
#(
    parameter int GLITCH_CNT_W = 8
)
`endif
;
    logic enable_sync_in;
    logic enable_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;
`ifdef ENABLE_GLITCH_CNT_EN
    logic                    glitch_clr;
    logic [GLITCH_CNT_W-1:0] glitch_count;

    modport master (
        output enable_sync_in,
        output glitch_clr,
        input  enable_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy,
        input  glitch_count
    );

    modport slave (
        input  enable_sync_in,
        input  glitch_clr,
        output enable_out,
        output rise_pulse,
        output fall_pulse,
        output busy,
        output glitch_count
    );
`else
    modport master (
        output enable_sync_in,
        input  enable_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  enable_sync_in,
        output enable_out,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
`endif
endinterface

// File: rtl/enable_debounce.sv
// enable_debounce: qualifies an already-synchronised enable level. A level change is
// accepted only after DEBOUNCE_CYCLES consecutive equal samples; the clean level and
// one-cycle rise/fall pulses are registered outputs. busy flags an open qualification.
// Optional macro ENABLE_GLITCH_CNT_EN adds a saturating counter of aborted
// qualifications with a synchronous clear (glitch_clr has priority over increment).
module enable_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef ENABLE_GLITCH_CNT_EN
    , parameter int GLITCH_CNT_W = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    enable_debounce_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value held on the edge before the accepting edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_QUAL_HI = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_QUAL_LO = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_out_q, enable_out_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;
    logic             busy_q, busy_d;

    // Next-state and qualification counter: one opposite sample restarts qualification.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (bus.enable_sync_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_QUAL_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_QUAL_HI: begin
                if (!bus.enable_sync_in) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!bus.enable_sync_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_QUAL_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_QUAL_LO: begin
                if (bus.enable_sync_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        enable_out_d = (state_d == ST_HIGH) || (state_d == ST_QUAL_LO);
        busy_d       = (state_d == ST_QUAL_HI) || (state_d == ST_QUAL_LO);
        rise_pulse_d = enable_out_d && !enable_out_q;
        fall_pulse_d = !enable_out_d && enable_out_q;
    end

    // State, counter and registered outputs; reset abandons any open qualification.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= ST_LOW;
            cnt_q        <= '0;
            enable_out_q <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable_out_q <= enable_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.enable_out = enable_out_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.fall_pulse = fall_pulse_q;
    assign bus.busy       = busy_q;

`ifdef ENABLE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
    logic                    glitch_ev;

    // Aborted qualification detection and saturating count with clear priority.
    always_comb begin
        glitch_ev = ((state_q == ST_QUAL_HI) && !bus.enable_sync_in) ||
                    ((state_q == ST_QUAL_LO) &&  bus.enable_sync_in);
        glitch_d  = glitch_q;
        if (bus.glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_ev && !(&glitch_q)) begin
            glitch_d = glitch_q + GLITCH_CNT_W'(1);
        end
    end

    // Glitch counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign bus.glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_enable_debounce.sv
// Testbench for enable_debounce: two instances (DEBOUNCE_CYCLES=16 and =1) share one
// randomised input stream and are compared each cycle against a run-length model.
`timescale 1ns/1ps
module tb_enable_debounce;

    localparam int GW   = 8;
    localparam int GMAX = (1 << GW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b0;
    logic clr   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #15.625 clk = ~clk;

`ifdef ENABLE_GLITCH_CNT_EN
    enable_debounce_if #(.GLITCH_CNT_W(GW)) bus16 ();
    enable_debounce_if #(.GLITCH_CNT_W(GW)) bus1 ();
    assign bus16.glitch_clr = clr;
    assign bus1.glitch_clr  = clr;
    enable_debounce #(.DEBOUNCE_CYCLES(16), .GLITCH_CNT_W(GW)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    enable_debounce #(.DEBOUNCE_CYCLES(1),  .GLITCH_CNT_W(GW)) dut1  (.clk(clk), .reset(reset), .bus(bus1));
`else
    enable_debounce_if bus16 ();
    enable_debounce_if bus1 ();
    enable_debounce #(.DEBOUNCE_CYCLES(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    enable_debounce #(.DEBOUNCE_CYCLES(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
`endif
    assign bus16.enable_sync_in = din;
    assign bus1.enable_sync_in  = din;

    // Reference model: accepted level plus length of the current run of samples that
    // disagree with it. The level flips once that run reaches the debounce length.
    int   m_deb [2] = '{16, 1};
    logic m_lvl [2];
    int   m_run [2];
    logic m_rise[2];
    logic m_fall[2];
    int   m_glitch[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i]    = 1'b0;
            m_run[i]    = 0;
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_glitch[i] = 0;
        end
    endtask

    task automatic model_edge(input logic d, input logic c);
        for (int i = 0; i < 2; i++) begin
            logic ev;
            ev        = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (d != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == m_deb[i]) begin
                    m_lvl[i] = d;
                    m_run[i] = 0;
                    if (d) m_rise[i] = 1'b1;
                    else   m_fall[i] = 1'b1;
                end
            end else begin
                if (m_run[i] > 0) ev = 1'b1;
                m_run[i] = 0;
            end
            if (c) m_glitch[i] = 0;
            else if (ev && m_glitch[i] < GMAX) m_glitch[i]++;
        end
    endtask

    task automatic check_all();
        check("d16_enable", 32'(bus16.enable_out), 32'(m_lvl[0]));
        check("d16_rise",   32'(bus16.rise_pulse), 32'(m_rise[0]));
        check("d16_fall",   32'(bus16.fall_pulse), 32'(m_fall[0]));
        check("d16_busy",   32'(bus16.busy),       32'(m_run[0] > 0));
        check("d1_enable",  32'(bus1.enable_out),  32'(m_lvl[1]));
        check("d1_rise",    32'(bus1.rise_pulse),  32'(m_rise[1]));
        check("d1_fall",    32'(bus1.fall_pulse),  32'(m_fall[1]));
        check("d1_busy",    32'(bus1.busy),        32'(m_run[1] > 0));
`ifdef ENABLE_GLITCH_CNT_EN
        check("d16_glitch", 32'(bus16.glitch_count), 32'(m_glitch[0]));
        check("d1_glitch",  32'(bus1.glitch_count),  32'(m_glitch[1]));
`endif
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 ns after the edge,
    // returns at the falling edge where the caller may change inputs.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(din, clr);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Synchronous-looking reset entry from a falling edge, held for n edges.
    task automatic reset_for(input int n);
        #5;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        for (int k = 0; k < n; k++) step();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset held 5 cycles with input low: everything stays zero.
        din = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t1_busy_in_reset", 32'(bus16.busy), 32'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Rise qualification timing, then fall qualification timing.
        din = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("t2_busy", 32'(bus16.busy),       32'(k <= 15));
            check("t2_en",   32'(bus16.enable_out), 32'(k >= 16));
            check("t2_rise", 32'(bus16.rise_pulse), 32'(k == 16));
        end
        din = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("t2_fall", 32'(bus16.fall_pulse), 32'(k == 16));
            check("t2_en_lo", 32'(bus16.enable_out), 32'(k < 16));
        end

        // Short high burst aborts, then a short low burst while high aborts.
        din = 1'b1;
        for (int k = 0; k < 10; k++) step();
        din = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_stay_lo", 32'(bus16.enable_out), 32'd0);
        end
        din = 1'b1;
        for (int k = 0; k < 18; k++) step();
        din = 1'b0;
        for (int k = 0; k < 5; k++) step();
        din = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_stay_hi", 32'(bus16.enable_out), 32'd1);
        end
`ifdef ENABLE_GLITCH_CNT_EN
        check("t3_glitch2", 32'(bus16.glitch_count), 32'd2);
`endif

        // Reset in the middle of a rise qualification.
        reset_for(2);
        din = 1'b0;
        step();
        din = 1'b1;
        for (int k = 0; k < 8; k++) step();
        #5;
        reset = 1'b1;
        model_reset();
        #1;
        check("t4_en_async",   32'(bus16.enable_out), 32'd0);
        check("t4_busy_async", 32'(bus16.busy),       32'd0);
        check_all();
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("t4_rise", 32'(bus16.rise_pulse), 32'(k == 16));
        end

`ifdef ENABLE_GLITCH_CNT_EN
        // Saturation after 300 glitches, then clear colliding with a glitch event.
        reset_for(1);
        for (int g = 0; g < 300; g++) begin
            din = 1'b1;
            step();
            din = 1'b0;
            step();
        end
        check("t6_sat", 32'(bus16.glitch_count), 32'(GMAX));
        din = 1'b1;
        step();
        din = 1'b0;
        clr = 1'b1;
        step();
        check("t6_clr_prio", 32'(bus16.glitch_count), 32'd0);
        clr = 1'b0;
`endif

        // Random runs with lengths straddling the debounce length, rare clear/reset.
        for (int r = 0; r < 250; r++) begin
            int len;
            len = $urandom_range(1, 20);
            din = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
`ifdef ENABLE_GLITCH_CNT_EN
                clr = ($urandom_range(0, 15) == 0);
`endif
                step();
            end
            if ($urandom_range(0, 40) == 0) reset_for($urandom_range(1, 3));
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
